// File: rtl/stack_pkg.sv
// stack_pkg: shared sizes and sequencer state encoding for the RAM-backed stack
package stack_pkg;
  localparam int STK_DW = 8;
  localparam int STK_AW = 5;
  localparam int STK_DEPTH = 32;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RD_SETUP,
    S_RD_CAPT
  } state_t;
endpackage

// File: rtl/stack_ptr.sv
// stack_ptr: saturating up/down stack pointer with full/empty decode
module stack_ptr
  import stack_pkg::*;
#(
  parameter int AW = STK_AW,
  parameter int DEPTH = STK_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        dec,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);
  logic [AW:0] sp;
  // pointer moves one step per strobe and never wraps past 0 or DEPTH
  always_ff @(posedge clk or negedge rst)
    if (!rst) sp <= '0;
    else if (inc && !full) sp <= sp + 1'b1;
    else if (dec && !empty) sp <= sp - 1'b1;
  assign count = sp;
  assign full  = sp == (AW+1)'(DEPTH);
  assign empty = sp == '0;
endmodule

// File: rtl/stack_ctrl.sv
// stack_ctrl: LIFO sequencer driving a 32x8 RAM with setup/pulse/hold phasing
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DW = STK_DW,
  parameter int AW = STK_AW,
  parameter int DEPTH = STK_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          ready,
  output logic          done,
  output logic          err,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_in,
  input  logic [DW-1:0] ram_out,
  output logic          ram_rws,
  output logic          ram_cs,
  output logic          ram_rst
);
  state_t state, nxt;
  logic is_idle, wr_go, rd_go, bad;
  logic [AW:0] sp_dec;
  assign is_idle = state == S_IDLE;
  assign wr_go   = is_idle && push && !pop && !full;
  assign rd_go   = is_idle && pop && !push && !empty;
  assign bad     = is_idle && ((push && pop) || (push && full) || (pop && empty));
  assign sp_dec  = count - 1'b1;
  stack_ptr #(.AW(AW), .DEPTH(DEPTH)) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc   (state == S_WR_HOLD),
    .dec   (state == S_RD_CAPT),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  // sequencing through the write and read phases
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:     nxt = wr_go ? S_WR_SETUP : rd_go ? S_RD_SETUP : S_IDLE;
      S_WR_SETUP: nxt = S_WR_PULSE;
      S_WR_PULSE: nxt = S_WR_HOLD;
      S_RD_SETUP: nxt = S_RD_CAPT;
      default:    nxt = S_IDLE;
    endcase
  end
  // state, status pulses, RAM address/data and popped word registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= S_IDLE;
      done    <= 1'b0;
      err     <= 1'b0;
      dout    <= '0;
      ram_adr <= '0;
      ram_in  <= '0;
    end else begin
      state <= nxt;
      done  <= (state == S_WR_HOLD) || (state == S_RD_CAPT);
      err   <= bad;
      if (wr_go) begin
        ram_adr <= count[AW-1:0];
        ram_in  <= din;
      end
      if (rd_go) ram_adr <= sp_dec[AW-1:0];
      if (state == S_RD_CAPT) dout <= ram_out;
    end
  assign ready   = is_idle;
  assign ram_cs  = (state == S_WR_PULSE) || (state == S_RD_SETUP) || (state == S_RD_CAPT);
  assign ram_rws = state == S_WR_PULSE;
  assign ram_rst = ~rst;
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed and random push/pop checks against a queue model with a 32x8 RAM
module tb_stack_ctrl;
  logic clk = 1'b0;
  logic rst, push, pop;
  logic [7:0] din, dout, ram_adr_in, ram_in, ram_out;
  logic ready, done, err, full, empty, ram_rws, ram_cs, ram_rst;
  logic [5:0] count;
  logic [4:0] ram_adr;
  logic [7:0] mem [32];
  logic [7:0] model [$];
  logic [7:0] last_pop;
  int tests = 0, fails = 0;
  int wr_cnt = 0, cs_cyc = 0, done_cnt = 0;
  logic [4:0] last_wr_adr;
  logic [7:0] last_wr_dat;
  logic prev_cs = 1'b0, prev_rws = 1'b0;
  stack_ctrl dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .dout(dout),
    .ready(ready), .done(done), .err(err), .full(full), .empty(empty), .count(count),
    .ram_adr(ram_adr), .ram_in(ram_in), .ram_out(ram_out), .ram_rws(ram_rws),
    .ram_cs(ram_cs), .ram_rst(ram_rst)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (ram_cs && ram_rws) mem[ram_adr] <= ram_in;
  assign ram_out = (ram_cs && !ram_rws) ? mem[ram_adr] : 8'h00;
  assign ram_adr_in = {3'b000, ram_adr};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (ram_cs && ram_rws) begin
      wr_cnt++;
      last_wr_adr = ram_adr;
      last_wr_dat = ram_in;
    end
    if (ram_cs) cs_cyc++;
    if (done) done_cnt++;
    if (rst && ram_cs && prev_cs) chk("rws_stable_under_cs", ram_rws, prev_rws);
    prev_cs = ram_cs;
    prev_rws = ram_rws;
  end
  task automatic run_op(input logic p, input logic q, input logic [7:0] d, input logic hold);
    int lat, busy, w0, c0, d0;
    logic bad;
    logic [7:0] exp_pop;
    bad = (p && q) || (p && model.size() == 32) || (q && model.size() == 0);
    w0 = wr_cnt; c0 = cs_cyc; d0 = done_cnt;
    exp_pop = 8'h00;
    push = p; pop = q; din = d;
    @(negedge clk);
    if (!hold) begin push = 1'b0; pop = 1'b0; end
    if (bad) begin
      chk("err_pulse", err, 1);
      chk("err_ready", ready, 1);
      push = 1'b0; pop = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("err_single_pulse", err, 0);
      chk("err_no_ram_access", cs_cyc - c0, 0);
      chk("err_no_done", done_cnt - d0, 0);
      chk("err_count_kept", count, model.size());
      chk("err_dout_kept", dout, last_pop);
    end else begin
      lat = 0; busy = 0;
      while (!done && lat < 12) begin
        if (!ready) busy++;
        @(negedge clk);
        lat++;
      end
      push = 1'b0; pop = 1'b0;
      if (p) model.push_back(d);
      else begin exp_pop = model.pop_back(); last_pop = exp_pop; end
      chk(p ? "push_latency" : "pop_latency", lat, p ? 3 : 2);
      chk("busy_cycles", busy, p ? 3 : 2);
      chk("ready_at_done", ready, 1);
      chk("err_quiet", err, 0);
      chk("count", count, model.size());
      chk("empty", empty, model.size() == 0);
      chk("full", full, model.size() == 32);
      chk("write_pulses", wr_cnt - w0, p ? 1 : 0);
      chk("cs_cycles", cs_cyc - c0, p ? 1 : 2);
      if (p) begin
        chk("write_adr", last_wr_adr, model.size() - 1);
        chk("write_dat", last_wr_dat, d);
      end else chk("pop_dout", dout, exp_pop);
      @(negedge clk);
      chk("done_once", done_cnt - d0, 1);
      chk("done_dropped", done, 0);
    end
  endtask
  initial begin
    rst = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00; last_pop = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cs", ram_cs, 0);
    chk("rst_rws", ram_rws, 0);
    chk("rst_adr", ram_adr_in, 0);
    chk("rst_ram_in", ram_in, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ram_rst", ram_rst, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("run_ram_rst", ram_rst, 0);
    run_op(1'b1, 1'b0, 8'hA5, 1'b0);
    chk("first_push_adr0", last_wr_adr, 0);
    chk("first_push_count", count, 1);
    run_op(1'b0, 1'b1, 8'h00, 1'b0);
    chk("first_pop_a5", dout, 8'hA5);
    for (int i = 1; i <= 32; i++) run_op(1'b1, 1'b0, 8'(i), 1'b0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 32);
    run_op(1'b1, 1'b0, 8'h33, 1'b0);
    chk("overflow_count", count, 32);
    for (int i = 32; i >= 1; i--) begin
      run_op(1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain_order", dout, i);
    end
    chk("drain_empty", empty, 1);
    run_op(1'b0, 1'b1, 8'h00, 1'b0);
    chk("underflow_dout", dout, 8'h01);
    for (int i = 0; i < 5; i++) run_op(1'b1, 1'b0, 8'($urandom), 1'b0);
    run_op(1'b1, 1'b1, 8'h77, 1'b0);
    chk("both_count", count, 5);
    run_op(1'b1, 1'b0, 8'h5C, 1'b1);
    run_op(1'b0, 1'b1, 8'h00, 1'b1);
    chk("held_pop_value", dout, 8'h5C);
    push = 1'b1; din = 8'hE7;
    @(negedge clk);
    push = 1'b0;
    @(negedge clk);
    chk("wr_pulse_cs", ram_cs, 1);
    chk("wr_pulse_rws", ram_rws, 1);
    rst = 1'b0;
    #1;
    chk("abort_cs_async", ram_cs, 0);
    chk("abort_count", count, 0);
    chk("abort_ready", ready, 1);
    model.delete();
    last_pop = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_abort_ready", ready, 1);
    chk("post_abort_empty", empty, 1);
    chk("post_abort_dout", dout, 0);
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5) run_op(1'b1, 1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
      else if (sel < 9) run_op(1'b0, 1'b1, 8'h00, 1'($urandom_range(0, 1)));
      else run_op(1'b1, 1'b1, 8'($urandom), 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
